wb_dbg_master: RTL
==================

Name: wb_dbg_master

Overview:
- Single-outstanding Wishbone classic master that turns a simple valid/ready command stream into bus cycles toward the debug register slave and other housekeeping slaves.
- Returns read data or write completion on a valid/ready response stream.
- Aborts with an error flag when no slave acknowledges within a bounded window.
- Keeps saturating transaction and error counters for bring-up visibility.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles cyc/stb are held without ack before abort; legal range 2..2^TO_W-1.
- TO_W, 8: width of the timeout counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready at a clock edge
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte lane enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  1=timeout abort
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte selects
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_dat_i  in  32  Wishbone read data
- txn_count  out  16  completed (acked) transactions, saturates at 16'hFFFF
- err_count  out  8  timeout aborts, saturates at 8'hFF

Behaviour:
- Reset: asynchronous and immediate, including mid-transaction.
  - State=IDLE.
  - All registered outputs are 0: cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_dat, rsp_err, txn_count, err_count.
  - Timeout counter is 0.
  - cmd_ready=0 while wb_rst_i is high.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1; it is combinational from state, and is 0 in all other states.
  - On cmd_valid: latch we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear the timeout counter, go to BUS.
- BUS:
  - cyc, stb, we, sel, adr, dat_o are held stable.
  - ack=1 at an edge:
    - Drop cyc and stb at that edge.
    - Set rsp_dat = we ? 0 : wbm_dat_i, rsp_err=0, rsp_valid=1.
    - Increment txn_count (saturating), go to RESP.
  - ack=0:
    - If the counter equals TIMEOUT_CYCLES-1: drop cyc/stb, set rsp_dat=0, rsp_err=1, rsp_valid=1, increment err_count (saturating), go to RESP.
    - Otherwise increment the counter.
  - Net effect: stb is held at most TIMEOUT_CYCLES cycles.
  - Ack on the final cycle wins over timeout.
- RESP:
  - rsp_* are held stable while rsp_ready=0.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - rsp_dat/rsp_err keep their values until the next response.
- Bus rules:
  - wbm_ack_i is sampled only in BUS; acks in IDLE or RESP (late acks after an abort) are ignored.
  - cyc/stb are low for at least two cycles between transactions (RESP plus IDLE), so a registered-ack slave always clears ack before the next strobe.
  - wbm_we/sel/adr/dat_o retain their last values after the cycle ends; they are don't-care while cyc=0.
- Latency with a one-cycle registered-ack slave:
  - cmd accepted at edge E0.
  - stb high from E0.
  - Slave ack high after E1, sampled at E2.
  - rsp_valid high from E2; cyc low from E2.
  - With rsp_ready tied high: back-to-back command accepted at E4.
- Only one transaction is outstanding; there is no buffering.

Test Plan:
- Write then read: write cmd adr=0x3000_0008 dat=0xA5A5_1234 sel=4'hF; then read adr=0x3000_0008 → write rsp err=0 dat=0; read rsp dat=0xA5A5_1234 err=0; txn_count=2; stb asserted exactly 2 cycles per transaction.
- Partial select: write adr 0x...0C dat=0xFFFF_FFFF sel=4'b0010 after reset; then read 0x...0C → rsp_dat=0x0000_FF00.
- Timeout: read adr 0x...04 (slave never acks) → stb high exactly 255 cycles; rsp_err=1, rsp_dat=0; err_count=1; txn_count unchanged. A forced late ack one cycle after abort is ignored.
- Backpressure: hold rsp_ready=0 for 10 cycles after a read → rsp_valid, rsp_dat, rsp_err stable; cmd_ready=0 throughout; next cmd accepted the cycle after rsp_ready=1 handshake.
- Reset mid-BUS: assert wb_rst_i while stb=1 → cyc/stb/rsp_valid/counters 0 immediately, without waiting for a clock edge; after release a new write completes normally.
- Saturation: force txn_count to 16'hFFFE via 2 extra transactions on a preloaded bench (or a small-width run) → stops at 16'hFFFF; err_count stops at 8'hFF after 256 timeouts with TIMEOUT_CYCLES=2.

Source files
------------

// File: rtl/wb_dbg_master_if.sv
// Command, response and Wishbone signal bundle for wb_dbg_master.
// The master modport is the view of wb_dbg_master itself; slave is the environment's view.
interface wb_dbg_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_dbg_master.sv
// Single-outstanding Wishbone classic master: command stream in, response stream out,
// with an ack timeout abort and saturating transaction/error counters.
module wb_dbg_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8,
    parameter int TXN_W          = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_dbg_master_if.master   bus,
    output logic [TXN_W-1:0]  txn_count,
    output logic [7:0]        err_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TXN_W-1:0] TXN_MAX = {TXN_W{1'b1}};
    localparam logic [7:0]       ERR_MAX = 8'hFF;

    state_t            state_r;
    state_t            state_s;
    logic              accept_s;
    logic              ack_s;
    logic              timeout_s;
    logic              tick_s;
    logic              release_s;

    logic              cyc_r;
    logic              stb_r;
    logic              we_r;
    logic [3:0]        sel_r;
    logic [31:0]       adr_r;
    logic [31:0]       dat_o_r;
    logic [TO_W-1:0]   to_cnt_r;

    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_dat_r;

    logic [TXN_W-1:0]  txn_cnt_r;
    logic [7:0]        err_cnt_r;

    // Ready only in IDLE and never while reset is asserted.
    assign bus.cmd_ready = (state_r == IDLE) & ~wb_rst_i;

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and per-cycle events; the ack is only looked at in BUS.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        ack_s     = 1'b0;
        timeout_s = 1'b0;
        tick_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept_s = 1'b1;
                    state_s  = BUS;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUS: begin
                // An ack on the last allowed cycle takes priority over the abort.
                if (bus.wbm_ack_i) begin
                    ack_s     = 1'b1;
                    state_s   = RESP;
                end else if (to_cnt_r == TO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    tick_s    = 1'b1;
                    state_s   = BUS;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    release_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bus request registers and ack timeout counter; request fields persist after the cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_r    <= 1'b0;
            stb_r    <= 1'b0;
            we_r     <= 1'b0;
            sel_r    <= 4'h0;
            adr_r    <= 32'h0000_0000;
            dat_o_r  <= 32'h0000_0000;
            to_cnt_r <= {TO_W{1'b0}};
        end else if (accept_s) begin
            cyc_r    <= 1'b1;
            stb_r    <= 1'b1;
            we_r     <= bus.cmd_we;
            sel_r    <= bus.cmd_sel;
            adr_r    <= bus.cmd_adr;
            dat_o_r  <= bus.cmd_dat;
            to_cnt_r <= {TO_W{1'b0}};
        end else if (ack_s || timeout_s) begin
            cyc_r    <= 1'b0;
            stb_r    <= 1'b0;
        end else if (tick_s) begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end
    end

    // Response registers; data and error flag stay put until the next response.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_dat_r   <= 32'h0000_0000;
        end else if (ack_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_dat_r   <= we_r ? 32'h0000_0000 : bus.wbm_dat_i;
        end else if (timeout_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_dat_r   <= 32'h0000_0000;
        end else if (release_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Saturating bring-up counters.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            txn_cnt_r <= {TXN_W{1'b0}};
            err_cnt_r <= 8'h00;
        end else begin
            if (ack_s && (txn_cnt_r != TXN_MAX)) begin
                txn_cnt_r <= txn_cnt_r + 1'b1;
            end
            if (timeout_s && (err_cnt_r != ERR_MAX)) begin
                err_cnt_r <= err_cnt_r + 8'h01;
            end
        end
    end

    assign bus.wbm_cyc_o = cyc_r;
    assign bus.wbm_stb_o = stb_r;
    assign bus.wbm_we_o  = we_r;
    assign bus.wbm_sel_o = sel_r;
    assign bus.wbm_adr_o = adr_r;
    assign bus.wbm_dat_o = dat_o_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_dat   = rsp_dat_r;
    assign txn_count     = txn_cnt_r;
    assign err_count     = err_cnt_r;
endmodule
